// File: rtl/fsm_pkg.sv
// Shared definitions for the windowed hit counter: FSM state encoding and
// the saturation-limit helper used to size the accumulator ceiling.
package fsm_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    // All-ones value of a w-bit counter, i.e. the value at which it saturates.
    function automatic logic [31:0] sat_limit(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter holding the per-window hit accumulator.
// clr has priority and restarts the count at zero with the saturation flag
// cleared; inc adds one unless the counter is already at its ceiling, in which
// case the blocked increment is remembered in sat.
module sat_counter
    import fsm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         sat
);

    localparam logic [W-1:0] LIMIT = W'(sat_limit(W));

    logic [W-1:0] r_q;
    logic         r_sat;

    // Accumulator and sticky saturation flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q   <= {W{1'b0}};
            r_sat <= 1'b0;
        end else if (clr) begin
            r_q   <= {W{1'b0}};
            r_sat <= 1'b0;
        end else if (inc) begin
            if (r_q == LIMIT) begin
                r_sat <= 1'b1;
            end else begin
                r_q <= r_q + W'(1);
            end
        end else begin
            r_q   <= r_q;
            r_sat <= r_sat;
        end
    end

    assign q   = r_q;
    assign sat = r_sat;

endmodule

// File: rtl/hit_window_counter.sv
// Windowed hit counter: counts asserted cycles of a detector match stream over
// a programmable number of clocks and presents each completed window's count
// through a valid/ready result register. Windows run back-to-back while
// enabled; a result that cannot be stored because the register is still full
// is discarded and flagged with a one-cycle drop pulse.
module hit_window_counter
    import fsm_pkg::*;
#(
    parameter int WIN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIN_W-1:0] win_len,
    input  logic             hit,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic [CNT_W-1:0] cnt_data,
    output logic             cnt_sat,
    output logic             drop
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(sat_limit(CNT_W));

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIN_W-1:0] r_remaining;
    logic [WIN_W-1:0] w_remaining_nxt;
    logic             w_clr;
    logic             w_inc;
    logic             w_close;

    logic [CNT_W-1:0] w_acc;
    logic             w_acc_sat;
    logic [CNT_W-1:0] w_final_cnt;
    logic             w_final_sat;

    logic             r_valid;
    logic [CNT_W-1:0] r_data;
    logic             r_sat;
    logic             r_drop;

    sat_counter #(
        .W (CNT_W)
    ) u_acc (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .inc (w_inc),
        .q   (w_acc),
        .sat (w_acc_sat)
    );

    // Closing count includes the hit sampled on the close edge itself, so fold
    // it into the accumulator value here rather than waiting a cycle.
    always_comb begin
        w_final_cnt = w_acc;
        w_final_sat = w_acc_sat;
        if (hit) begin
            if (w_acc == CNT_LIMIT) begin
                w_final_sat = 1'b1;
            end else begin
                w_final_cnt = w_acc + CNT_W'(1);
            end
        end else begin
            w_final_cnt = w_acc;
        end
    end

    // Next-state, window down-counter and accumulator control.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_clr           = 1'b0;
        w_inc           = 1'b0;
        w_close         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en && (win_len != {WIN_W{1'b0}})) begin
                    w_state_nxt     = ST_COUNT;
                    w_remaining_nxt = win_len;
                    w_clr           = 1'b1;
                end else begin
                    w_state_nxt     = ST_IDLE;
                end
            end
            ST_COUNT: begin
                if (!en) begin
                    // Abort: partial count thrown away, nothing reported.
                    w_state_nxt     = ST_IDLE;
                    w_remaining_nxt = {WIN_W{1'b0}};
                    w_clr           = 1'b1;
                end else if (r_remaining == WIN_W'(1)) begin
                    // Close edge: restart immediately if another window is asked for.
                    w_close = 1'b1;
                    w_clr   = 1'b1;
                    if (win_len != {WIN_W{1'b0}}) begin
                        w_state_nxt     = ST_COUNT;
                        w_remaining_nxt = win_len;
                    end else begin
                        w_state_nxt     = ST_IDLE;
                        w_remaining_nxt = {WIN_W{1'b0}};
                    end
                end else begin
                    w_inc           = hit;
                    w_remaining_nxt = r_remaining - WIN_W'(1);
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_remaining_nxt = {WIN_W{1'b0}};
                w_clr           = 1'b1;
            end
        endcase
    end

    // State and window length registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= {WIN_W{1'b0}};
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

    // Result register: load on close when free or being drained, else drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= {CNT_W{1'b0}};
            r_sat   <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            if (w_close) begin
                if (!r_valid || cnt_ready) begin
                    r_valid <= 1'b1;
                    r_data  <= w_final_cnt;
                    r_sat   <= w_final_sat;
                end else begin
                    r_drop  <= 1'b1;
                end
            end else if (r_valid && cnt_ready) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end
        end
    end

    assign cnt_valid = r_valid;
    assign cnt_data  = r_data;
    assign cnt_sat   = r_sat;
    assign drop      = r_drop;

endmodule

// File: doc/hit_window_counter.md
# hit_window_counter

Windowed event counter downstream of the overlapping Mealy `101` sequence detector. It consumes the detector's single-bit `out` stream on `hit` and counts asserted cycles over a programmable window of bit-clocks. At window close it presents the count through a valid/ready output register. Windows run back-to-back while enabled, giving the host a hits-per-window rate for the serial line.

## Interface
- `WIN_W`, 8: width of window length; max window 2^WIN_W−1 cycles
- `CNT_W`, 8: width of hit count; saturates at 2^CNT_W−1

- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `en`  in  1  run enable; windows start/continue only while high
- `win_len`  in  WIN_W  window length in cycles, sampled at each window start; 0 = do not start
- `hit`  in  1  detector match (sd_101 `out`), sampled every edge in COUNT
- `cnt_valid`  out  1  result register holds an unconsumed count
- `cnt_ready`  in  1  consumer accepts result when `cnt_valid && cnt_ready`
- `cnt_data`  out  CNT_W  hit count of the completed window
- `cnt_sat`  out  1  companion to `cnt_data`: count saturated in that window
- `drop`  out  1  one-cycle pulse: completed window discarded because result register still full

## Operation
- Reset (`rst`=0, async): state IDLE; `cnt_valid`=0, `cnt_data`=0, `cnt_sat`=0, `drop`=0; internal count/remaining = 0.
- States: IDLE, COUNT.
- IDLE→COUNT on edge with `en`=1 and `win_len`≠0: latch `remaining`=`win_len`, `acc`=0, `sat`=0.
- COUNT, each edge:
  - `acc` += `hit`, saturating at 2^CNT_W−1; `sat` set when an increment is blocked.
  - `remaining` decrements.
- `en`=0 in COUNT: abort at that edge (the hit on that edge is not counted). Partial count discarded, no result, no `drop`, go IDLE.
- Window close is the edge where `remaining`=1 and `en`=1. The final count includes that edge's `hit`.
  - If the result register is empty, or is being consumed on the same edge (`cnt_valid && cnt_ready`): load `cnt_data`/`cnt_sat`, `cnt_valid`=1.
  - Otherwise: keep the old result, pulse `drop` for one cycle.
  - Then, if `win_len`≠0, reload and stay in COUNT with no gap cycle; else go IDLE.
- Output register:
  - `cnt_valid` falls on the consuming edge unless reloaded on that same edge.
  - `cnt_data`/`cnt_sat` stay stable while `cnt_valid`=1 and unconsumed.
  - `cnt_ready` is ignored while `cnt_valid`=0.
- `en` does not affect a pending result; it stays until consumed.

## Timing
- Start edge t0 (IDLE→COUNT). Hits are sampled at edges t1..tL, L=`win_len`. `cnt_valid` is high in the cycle after tL (zero added latency).
- Back-to-back windows: the next window's first sample is edge tL+1.
- Minimum window L=1: one hit sample per result. A result is produced every cycle and must be consumed every cycle to avoid `drop`.
- `drop` is high for exactly one cycle after the close edge.
- Async reset mid-window clears everything immediately. Operation restarts from IDLE after the first edge with `rst`=1.

## Structure
- Shared package `fsm_pkg`: state typedef (IDLE, COUNT) and saturation-limit helper constant derived from `CNT_W`.
- Sub-module `sat_counter` (parameter `W`; inputs `clr`, `inc`; outputs `q`, `sat`) holds the accumulator. Top holds the FSM, window down-counter and output register.
- Integration top wires `sd_101.out` → `hit`, shared `clk`/`rst`.

## Test plan
- Reset then `en`=1, `win_len`=8, `cnt_ready`=1, hits on samples 2,4,6 → one cycle after 8th sample `cnt_valid`=1, `cnt_data`=3, `cnt_sat`=0.
- `CNT_W`=2, `win_len`=6, `hit` high all 6 samples → `cnt_data`=3, `cnt_sat`=1.
- `win_len`=4, `cnt_ready`=0, 2 hits then 1 hit → first result 2 held stable; at second close `drop` pulses one cycle, `cnt_data` still 2. Raise `cnt_ready` → `cnt_valid` falls next edge.
- `win_len`=4 back-to-back, `cnt_ready` high only on close edges → no `drop`, `cnt_valid` reloaded continuously, counts per window match hit pattern.
- `en` dropped after 3 of 8 samples with 2 hits → IDLE, no `cnt_valid`, no `drop`. Re-enable → fresh count starting from 0.
- `rst` asserted mid-window with `cnt_valid`=1 → all outputs 0 immediately. `win_len`=0 with `en`=1 → stays IDLE.
